// File: rtl/fpaddsub_norm_shift_seq.sv
// Multi-pass normalization sequencer: drives an external 0..15-bit left shifter
// until the mantissa MSB is set, the mantissa is zero, or the exponent floor is reached.
module fpaddsub_norm_shift_seq #(
    parameter int DWIDTH   = 32,
    parameter int EWIDTH   = 8,
    parameter int MAX_PASS = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH:0]   in_mant,
    input  logic [EWIDTH-1:0] in_exp,
    output logic [DWIDTH:0]   sh_mant,
    output logic [3:0]        sh_amt,
    input  logic [DWIDTH:0]   sh_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH:0]   out_mant,
    output logic [EWIDTH-1:0] out_exp,
    output logic [5:0]        out_shift,
    output logic              out_zero,
    output logic              out_denorm,
    output logic              busy
);

    localparam int MW  = DWIDTH + 1;
    localparam int LZW = $clog2(DWIDTH + 2);
    localparam int CW  = LZW + EWIDTH + 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [DWIDTH:0]     mant_reg, mant_next;
    logic [EWIDTH-1:0]   exp_reg, exp_next;
    logic [5:0]          tot_reg, tot_next;
    logic [3:0]          amt_reg, amt_next;
    logic [DWIDTH:0]     sh_mant_reg, sh_mant_next;
    logic [3:0]          sh_amt_reg, sh_amt_next;
    logic                zero_reg, zero_next;
    logic                denorm_reg, denorm_next;

    logic [LZW-1:0]      lz_c;
    logic [CW-1:0]       exp_lim_c;
    logic [CW-1:0]       amt_lim_c;
    logic [3:0]          amt_c;

    // Leading-zero count: the highest set bit wins since it is visited last.
    always_comb begin
        lz_c = LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (mant_reg[i]) begin
                lz_c = LZW'(DWIDTH - i);
            end
        end
    end

    // Pass amount limited by the shifter range and by keeping exp >= 1.
    always_comb begin
        exp_lim_c = (exp_reg != '0) ? (CW'(exp_reg) - CW'(1)) : '0;
        amt_lim_c = CW'(MAX_PASS);
        if (CW'(lz_c) < amt_lim_c) begin
            amt_lim_c = CW'(lz_c);
        end
        if (exp_lim_c < amt_lim_c) begin
            amt_lim_c = exp_lim_c;
        end
        amt_c = amt_lim_c[3:0];
    end

    always_comb begin
        state_next   = state_reg;
        mant_next    = mant_reg;
        exp_next     = exp_reg;
        tot_next     = tot_reg;
        amt_next     = amt_reg;
        sh_mant_next = sh_mant_reg;
        sh_amt_next  = sh_amt_reg;
        zero_next    = zero_reg;
        denorm_next  = denorm_reg;

        case (state_reg)
            IDLE: begin
                sh_amt_next = '0;
                if (in_valid) begin
                    mant_next  = in_mant;
                    exp_next   = in_exp;
                    tot_next   = '0;
                    state_next = EVAL;
                end
            end
            EVAL: begin
                if (mant_reg == '0) begin
                    exp_next   = '0;
                    zero_next  = 1'b1;
                    state_next = DONE;
                end else if (lz_c == '0) begin
                    state_next = DONE;
                end else if (amt_c == '0) begin
                    denorm_next = 1'b1;
                    state_next  = DONE;
                end else begin
                    amt_next     = amt_c;
                    sh_mant_next = mant_reg;
                    sh_amt_next  = amt_c;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                mant_next   = sh_res;
                exp_next    = exp_reg - EWIDTH'(amt_reg);
                tot_next    = tot_reg + 6'(amt_reg);
                sh_amt_next = '0;
                state_next  = EVAL;
            end
            DONE: begin
                if (out_ready) begin
                    zero_next   = 1'b0;
                    denorm_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            mant_reg    <= '0;
            exp_reg     <= '0;
            tot_reg     <= '0;
            amt_reg     <= '0;
            sh_mant_reg <= '0;
            sh_amt_reg  <= '0;
            zero_reg    <= 1'b0;
            denorm_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mant_reg    <= mant_next;
            exp_reg     <= exp_next;
            tot_reg     <= tot_next;
            amt_reg     <= amt_next;
            sh_mant_reg <= sh_mant_next;
            sh_amt_reg  <= sh_amt_next;
            zero_reg    <= zero_next;
            denorm_reg  <= denorm_next;
        end
    end

    // in_ready is gated by reset so every output reads 0 while reset is held.
    assign in_ready   = (state_reg == IDLE) && rst;
    assign busy       = (state_reg != IDLE);
    assign out_valid  = (state_reg == DONE);
    assign sh_mant    = sh_mant_reg;
    assign sh_amt     = sh_amt_reg;
    assign out_mant   = mant_reg;
    assign out_exp    = exp_reg;
    assign out_shift  = tot_reg;
    assign out_zero   = zero_reg;
    assign out_denorm = denorm_reg;

endmodule
